q_pulse_accumulator: RTL and testbench
======================================

Q_PULSE_ACCUMULATOR -- requirements
Module: q_pulse_accumulator

Interface
REQ-001 Parameter BUS_WIDTH, default 10, width of the measured-charge bus.
REQ-002 Parameter WTD_BUS_WIDTH, default 3, watchdog counter width; WTD_MAX = 2**WTD_BUS_WIDTH-1.
REQ-003 Parameter Q_PER_PULSE, default 10, charge quantum added per detected pulse.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 enable  input  1  block enable; low aborts any measurement.
REQ-007 start  input  1  level request to measure; sampled in IDLE.
REQ-008 q_serialized  input  1  raw pulse train from the resonant system, asynchronous to clk.
REQ-009 q_measured  output  BUS_WIDTH  last completed charge measurement.
REQ-010 ready  output  1  one-cycle strobe: q_measured just updated.
REQ-011 busy  output  1  high in WAIT_FIRST and ACCUM.
REQ-012 saturated  output  1  last completed measurement clipped at full scale.

Function
REQ-013 q_serialized SHALL pass a 2-flop synchronizer, then a rising-edge detector; a raw rising edge yields a one-cycle edge strobe 3 clk edges later.
REQ-014 Pulses SHALL be detected only if high ≥2 cycles and low ≥2 cycles; narrower pulses are unspecified.
REQ-015 States: IDLE, WAIT_FIRST, ACCUM, DONE.
REQ-016 IDLE -> WAIT_FIRST when enable=1 and start=1; accumulator, watchdog and internal saturation flag cleared on entry.
REQ-017 WAIT_FIRST -> ACCUM on the first edge strobe, which is accumulated; watchdog cleared.
REQ-018 WAIT_FIRST -> DONE when watchdog == WTD_MAX with no edge that cycle (no-pulse measurement reports 0).
REQ-019 ACCUM: each edge strobe adds Q_PER_PULSE and clears watchdog; otherwise watchdog increments by 1.
REQ-020 ACCUM -> DONE when watchdog == WTD_MAX with no edge that cycle; ready is thus high 8 cycles after the last edge strobe (WTD_BUS_WIDTH=3).
REQ-021 Edge strobe coinciding with watchdog == WTD_MAX: edge wins, it is accumulated and the state stays ACCUM.
REQ-022 DONE lasts exactly one cycle: q_measured <= accumulator, saturated <= internal flag, ready=1; then -> IDLE.
REQ-023 From IDLE, start still high re-arms the next cycle, giving back-to-back measurements.
REQ-024 Addition SHALL be computed at BUS_WIDTH+1 bits and clamp to 2**BUS_WIDTH-1; any clamp sets the internal saturation flag.
REQ-025 enable=0 in any state -> IDLE next cycle, no ready, q_measured and saturated held.
REQ-026 Edges in IDLE or DONE SHALL be ignored; the synchronizer runs continuously.
REQ-027 ready SHALL never be high in two consecutive cycles.

Reset
REQ-028 rst=0 asynchronously forces IDLE and sets q_measured=0, ready=0, busy=0, saturated=0, accumulator=0, watchdog=0 and synchronizer flops to 0.
REQ-029 Reset mid-measurement discards the partial sum; after release the block waits in IDLE for enable and start.

Structure
REQ-030 Package q_meas_pkg SHALL hold the state enum and the WTD_MAX/full-scale helper constants.
REQ-031 Sub-module sync_edge_detect (2-flop synchronizer plus rising-edge strobe) SHALL be instantiated once.

Verification
REQ-032 start=enable=1, 31 pulses of 3 cycles high / 3 low -> single ready, q_measured=310, saturated=0.
REQ-033 110 pulses -> q_measured=1023, saturated=1; the next 5-pulse run -> 50, saturated=0.
REQ-034 start=enable=1, q_serialized held 0 -> ready 8 cycles after WAIT_FIRST entry, q_measured=0.
REQ-035 enable dropped after 12 pulses -> IDLE, no ready, q_measured keeps the previous value.
REQ-036 rst=0 pulsed mid-ACCUM -> all outputs 0 immediately; a following 4-pulse run -> 40.
REQ-037 Pulse gap of exactly 7 low cycles after an edge strobe -> still one measurement (edge-wins rule).

Source files
------------

// File: rtl/q_pulse_accumulator_pkg.sv
// Shared types and scale helpers for the charge pulse accumulator.
package q_meas_pkg;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FIRST = 2'd1,
    S_ACCUM      = 2'd2,
    S_DONE       = 2'd3
  } meas_state_e;

  localparam int unsigned BUS_WIDTH_DEF     = 10;
  localparam int unsigned WTD_BUS_WIDTH_DEF = 3;
  localparam int unsigned Q_PER_PULSE_DEF   = 10;

  function automatic int unsigned wtd_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int unsigned full_scale(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/q_pulse_accumulator_if.sv
// Control/result bundle between the accumulator and its host.
interface q_pulse_accumulator_if #(
  parameter int BUS_WIDTH = 10
);
  logic                 enable;
  logic                 start;
  logic                 q_serialized;
  logic [BUS_WIDTH-1:0] q_measured;
  logic                 ready;
  logic                 busy;
  logic                 saturated;

  modport master (
    output enable, start, q_serialized,
    input  q_measured, ready, busy, saturated
  );

  modport slave (
    input  enable, start, q_serialized,
    output q_measured, ready, busy, saturated
  );
endinterface

// File: rtl/q_pulse_accumulator_sync_edge_detect.sv
// Two-flop synchronizer for the raw pulse train plus a registered rising-edge strobe;
// a raw rising edge appears as a one-cycle strobe three clock edges later.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic strobe_o
);
  logic meta_q;
  logic sync_q;
  logic sync_dly_q;
  logic strobe_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      sync_dly_q <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      meta_q     <= d_i;
      sync_q     <= meta_q;
      sync_dly_q <= sync_q;
      strobe_q   <= sync_q & ~sync_dly_q;
    end
  end

  assign strobe_o = strobe_q;
endmodule

// File: rtl/q_pulse_accumulator.sv
// Counts synchronized charge pulses into a saturating sum; a measurement closes
// once the watchdog sees WTD_MAX+1 quiet cycles after the last pulse (or arming).
//
// state        | meaning
// S_IDLE       | waiting for enable && start
// S_WAIT_FIRST | armed, no pulse yet, watchdog running
// S_ACCUM      | at least one pulse accumulated, watchdog running
// S_DONE       | one-cycle result publish (ready high)
module q_pulse_accumulator
  import q_meas_pkg::*;
#(
  parameter int BUS_WIDTH     = 10,
  parameter int WTD_BUS_WIDTH = 3,
  parameter int Q_PER_PULSE   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  q_pulse_accumulator_if.slave  bus
);
  localparam int unsigned WTD_MAX    = wtd_max(WTD_BUS_WIDTH);
  localparam int unsigned FULL_SCALE = full_scale(BUS_WIDTH);

  localparam logic [WTD_BUS_WIDTH-1:0] WTD_TC = WTD_BUS_WIDTH'(WTD_MAX);
  localparam logic [BUS_WIDTH:0]       FS_EXT = (BUS_WIDTH+1)'(FULL_SCALE);
  localparam logic [BUS_WIDTH:0]       Q_EXT  = (BUS_WIDTH+1)'(Q_PER_PULSE);

  meas_state_e              state_q;
  logic [BUS_WIDTH-1:0]     acc_q;
  logic [BUS_WIDTH-1:0]     q_meas_q;
  logic [WTD_BUS_WIDTH-1:0] wtd_q;
  logic                     sat_int_q;
  logic                     sat_q;
  logic                     ready_q;
  logic                     busy_q;

  logic                     edge_stb;
  logic [BUS_WIDTH:0]       sum_ext;
  logic                     clip;
  logic [BUS_WIDTH-1:0]     acc_d;
  logic                     sat_d;

  sync_edge_detect u_sync (
    .clk      (clk),
    .rst      (rst),
    .d_i      (bus.q_serialized),
    .strobe_o (edge_stb)
  );

  // One extra bit of headroom so the overflow is visible before clamping.
  always_comb begin
    sum_ext = {1'b0, acc_q} + Q_EXT;
    clip    = (sum_ext > FS_EXT);
    acc_d   = clip ? FS_EXT[BUS_WIDTH-1:0] : sum_ext[BUS_WIDTH-1:0];
    sat_d   = sat_int_q | clip;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      q_meas_q  <= '0;
      wtd_q     <= '0;
      sat_int_q <= 1'b0;
      sat_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.enable && bus.start) begin
            state_q   <= S_WAIT_FIRST;
            acc_q     <= '0;
            wtd_q     <= '0;
            sat_int_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        S_WAIT_FIRST, S_ACCUM: begin
          // Pulse beats watchdog expiry when both land in the same cycle.
          if (!bus.enable) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (edge_stb) begin
            state_q   <= S_ACCUM;
            acc_q     <= acc_d;
            sat_int_q <= sat_d;
            wtd_q     <= '0;
          end else if (wtd_q == WTD_TC) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            q_meas_q <= acc_q;
            sat_q    <= sat_int_q;
          end else begin
            wtd_q <= wtd_q + WTD_BUS_WIDTH'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.q_measured = q_meas_q;
  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;
  assign bus.saturated  = sat_q;
endmodule

// File: tb/tb_q_pulse_accumulator.sv
// Self-checking bench: timestamp-based reference model, directed scenarios and random traffic.
module tb_q_pulse_accumulator;
  localparam int BW        = 10;
  localparam int QPP       = 10;
  localparam int FS        = 1023;
  localparam int QUIET_END = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic st  = 1'b0;
  logic qs  = 1'b0;

  always #5 clk = ~clk;

  q_pulse_accumulator_if #(.BUS_WIDTH(BW)) bus ();

  assign bus.enable       = en;
  assign bus.start        = st;
  assign bus.q_serialized = qs;

  q_pulse_accumulator #(
    .BUS_WIDTH     (BW),
    .WTD_BUS_WIDTH (3),
    .Q_PER_PULSE   (QPP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: a measurement is open from arming until QUIET_END edges pass with
  // no detected pulse since the later of arming or the last pulse.
  bit       m_active, m_cool, m_clip;
  int       m_sum, m_cyc, m_last;
  bit [3:0] m_hist;
  int       exp_q;
  bit       exp_sat, exp_ready, exp_busy;
  int       n_ready;
  bit       prev_ready;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_cool = 0; m_clip = 0;
    m_sum = 0; m_last = 0; m_hist = '0;
    exp_q = 0; exp_sat = 0; exp_ready = 0; exp_busy = 0;
  endfunction

  // Pulse seen by the measurement at this edge: raw sampled 1 three edges
  // earlier after having been sampled 0 four edges earlier.
  function automatic void model_edge(input bit e, input bit s, input bit raw);
    bit pulse;
    pulse = m_hist[2] & ~m_hist[3];
    m_cyc++;
    exp_ready = 0;
    if (m_cool) begin
      m_cool = 0;
    end else if (!m_active) begin
      if (e && s) begin
        m_active = 1; m_sum = 0; m_clip = 0; m_last = m_cyc;
      end
    end else if (!e) begin
      m_active = 0;
    end else if (pulse) begin
      m_sum = m_sum + QPP;
      if (m_sum > FS) begin m_sum = FS; m_clip = 1; end
      m_last = m_cyc;
    end else if (m_cyc - m_last == QUIET_END) begin
      exp_q = m_sum; exp_sat = m_clip; exp_ready = 1;
      m_active = 0; m_cool = 1;
    end
    exp_busy = m_active;
    m_hist = {m_hist[2:0], raw};
  endfunction

  task automatic compare();
    chk("q_measured", int'(bus.q_measured), exp_q);
    chk("saturated", int'(bus.saturated), int'(exp_sat));
    chk("ready", int'(bus.ready), int'(exp_ready));
    chk("busy", int'(bus.busy), int'(exp_busy));
    if (bus.ready) begin
      n_ready++;
      chk("ready_not_consecutive", int'(prev_ready), 0);
    end
    prev_ready = bus.ready;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(en, st, qs);
    @(negedge clk);
    compare();
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      qs = 1'b1; repeat (hi) step();
      qs = 1'b0; repeat (lo) step();
    end
  endtask

  task automatic idle(input int k);
    qs = 1'b0;
    repeat (k) step();
  endtask

  task automatic arm();
    en = 1'b1; st = 1'b1; step(); st = 1'b0;
  endtask

  task automatic run(input int n, input int hi, input int lo);
    arm();
    pulses(n, hi, lo);
    idle(14);
  endtask

  initial begin
    int r0;
    int ready_at;
    int rem;

    model_reset();
    m_cyc = 0; n_ready = 0; prev_ready = 0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_q", int'(bus.q_measured), 0);
    chk("reset_ready", int'(bus.ready), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_sat", int'(bus.saturated), 0);
    rst = 1'b1;

    // 31 pulses, 3 high / 3 low
    r0 = n_ready;
    run(31, 3, 3);
    chk("t31_ready_count", n_ready - r0, 1);
    chk("t31_q", int'(bus.q_measured), 310);
    chk("t31_model_q", exp_q, 310);
    chk("t31_sat", int'(bus.saturated), 0);

    // saturation then recovery
    run(110, 3, 3);
    chk("t110_q", int'(bus.q_measured), 1023);
    chk("t110_sat", int'(bus.saturated), 1);
    chk("t110_model_sat", int'(exp_sat), 1);
    run(5, 2, 2);
    chk("t5_q", int'(bus.q_measured), 50);
    chk("t5_sat", int'(bus.saturated), 0);

    // enable dropped mid-measurement
    r0 = n_ready;
    arm();
    pulses(12, 3, 3);
    en = 1'b0;
    step();
    chk("abort_busy", int'(bus.busy), 0);
    idle(14);
    chk("abort_ready_count", n_ready - r0, 0);
    chk("abort_q_held", int'(bus.q_measured), 50);

    // asynchronous reset mid-accumulation
    arm();
    pulses(6, 3, 3);
    chk("pre_reset_busy", int'(bus.busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_q", int'(bus.q_measured), 0);
    chk("async_reset_busy", int'(bus.busy), 0);
    chk("async_reset_ready", int'(bus.ready), 0);
    model_reset();
    qs = 1'b0;
    @(posedge clk);
    @(negedge clk);
    compare();
    rst = 1'b1;
    run(4, 2, 2);
    chk("post_reset_q", int'(bus.q_measured), 40);

    // no pulses: ready 8 cycles after arming
    arm();
    chk("nopulse_busy", int'(bus.busy), 1);
    ready_at = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (bus.ready && ready_at < 0) ready_at = i;
    end
    chk("nopulse_latency", ready_at, 8);
    chk("nopulse_q", int'(bus.q_measured), 0);

    // pulse spacing 8: edge coincides with watchdog expiry, edge wins
    r0 = n_ready;
    run(2, 3, 5);
    chk("gap8_ready_count", n_ready - r0, 1);
    chk("gap8_q", int'(bus.q_measured), 20);
    // pulse spacing 9: measurement closes before the second pulse
    r0 = n_ready;
    run(2, 3, 6);
    chk("gap9_ready_count", n_ready - r0, 1);
    chk("gap9_q", int'(bus.q_measured), 10);

    // start held high: back-to-back empty measurements
    r0 = n_ready;
    en = 1'b1; st = 1'b1;
    repeat (20) step();
    st = 1'b0;
    chk("b2b_ready_count", n_ready - r0, 2);
    idle(10);

    // random traffic
    rem = 0;
    for (int i = 0; i < 4000; i++) begin
      en = ($urandom_range(0, 199) != 0);
      st = ($urandom_range(0, 7) == 0);
      if (rem == 0) begin
        qs = ~qs;
        if (qs) rem = $urandom_range(2, 4);
        else if ($urandom_range(0, 3) == 0) rem = $urandom_range(7, 14);
        else rem = $urandom_range(2, 6);
      end
      rem--;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
